// File: rtl/hsid_stream_ctrl.sv
// Sequencer for one hsid_main classification job: fetches the captured pixel and library
// words over an OBI-style read port, buffers them in a small FIFO and streams them out.
module hsid_stream_ctrl #(
  parameter int unsigned WORD_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned HSI_BANDS        = 128,
  parameter int unsigned HSI_LIBRARY_SIZE = 256,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  input  logic                                cfg_clear,
  input  logic [ADDR_WIDTH-1:0]               cfg_base_addr,
  input  logic [$clog2(HSI_BANDS)-1:0]        cfg_bands,
  input  logic [$clog2(HSI_LIBRARY_SIZE)-1:0] cfg_lib_size,
  output logic                                busy,
  output logic                                irq,
  output logic                                err,
  output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] res_min_ref,
  output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] res_max_ref,
  output logic [WORD_WIDTH-1:0]               res_min_value,
  output logic [WORD_WIDTH-1:0]               res_max_value,
  output logic                                mem_req,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  input  logic                                mem_gnt,
  input  logic                                mem_rvalid,
  input  logic [WORD_WIDTH-1:0]               mem_rdata,
  output logic                                hm_start,
  output logic                                hm_clear,
  output logic [$clog2(HSI_BANDS)-1:0]        hm_bands,
  output logic [$clog2(HSI_LIBRARY_SIZE)-1:0] hm_lib_size,
  output logic                                hm_vctr_valid,
  output logic [WORD_WIDTH-1:0]               hm_vctr,
  input  logic                                hm_ready,
  input  logic                                hm_done,
  input  logic [$clog2(HSI_LIBRARY_SIZE)-1:0] hm_mse_min_ref,
  input  logic [$clog2(HSI_LIBRARY_SIZE)-1:0] hm_mse_max_ref,
  input  logic [WORD_WIDTH-1:0]               hm_mse_min_value,
  input  logic [WORD_WIDTH-1:0]               hm_mse_max_value
);

  localparam int unsigned BW = $clog2(HSI_BANDS);
  localparam int unsigned LW = $clog2(HSI_LIBRARY_SIZE);
  localparam int unsigned CW = $clog2(HSI_BANDS / 2 * (HSI_LIBRARY_SIZE + 1)) + 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = PW + 1;
  localparam int unsigned SW = FW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_STREAM, S_WAIT_DONE} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [BW-1:0]         r_bands;
  logic [LW-1:0]         r_lib;
  logic [CW-1:0]         r_nwords, r_req_cnt, r_pop_cnt;
  logic [FW-1:0]         r_infl, r_fcnt;
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                  r_pend, r_err, r_irq, r_hm_start, r_hm_clear;
  logic [LW-1:0]         r_min_ref, r_max_ref;
  logic [WORD_WIDTH-1:0] r_min_val, r_max_val;

  logic                  w_accept, w_clear, w_cfg_bad, w_latch;
  logic                  w_mem_req, w_fire, w_push, w_pop, w_credit_ok, w_finish;
  logic [ADDR_WIDTH-1:0] w_sel_base, w_addr_sum;
  logic [BW-1:0]         w_sel_bands;
  logic [LW-1:0]         w_sel_lib;
  logic [CW-1:0]         w_nwords;

  // A fresh cfg_start wins; otherwise a start deferred behind a clear uses the latched config
  assign w_sel_base  = cfg_start ? cfg_base_addr : r_base;
  assign w_sel_bands = cfg_start ? cfg_bands     : r_bands;
  assign w_sel_lib   = cfg_start ? cfg_lib_size  : r_lib;
  assign w_cfg_bad   = (w_sel_bands == '0) || w_sel_bands[0] || (w_sel_lib == '0);
  assign w_nwords    = CW'(w_sel_bands >> 1) * (CW'(w_sel_lib) + CW'(1));
  assign w_latch     = w_accept || (w_clear && cfg_start);

  assign w_credit_ok = (SW'(r_infl) + SW'(r_fcnt)) < SW'(FIFO_DEPTH);
  assign w_mem_req   = (r_state == S_STREAM) && (r_req_cnt < r_nwords) && w_credit_ok;
  assign w_fire      = w_mem_req && mem_gnt;
  assign w_push      = mem_rvalid && (r_infl != '0);
  assign w_pop       = (r_state == S_STREAM) && (r_fcnt != '0) && hm_ready;
  assign w_finish    = (r_state == S_WAIT_DONE) && hm_done;
  assign w_addr_sum  = r_base + ADDR_WIDTH'({r_req_cnt, 2'b00});

  // Next-state logic
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_clear  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_clear) begin
          w_clear = 1'b1;
        end else if (cfg_start || r_pend) begin
          w_accept = 1'b1;
          if (!w_cfg_bad) w_next = S_START;
        end
      end
      S_START:     if (!r_hm_start && hm_ready) w_next = S_STREAM;
      S_STREAM:    if (r_pop_cnt == r_nwords) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (hm_done) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Control, config and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base     <= '0;
      r_bands    <= '0;
      r_lib      <= '0;
      r_pend     <= 1'b0;
      r_err      <= 1'b0;
      r_irq      <= 1'b0;
      r_hm_start <= 1'b0;
      r_hm_clear <= 1'b0;
      r_min_ref  <= '0;
      r_max_ref  <= '0;
      r_min_val  <= '0;
      r_max_val  <= '0;
    end else begin
      r_hm_start <= w_accept && !w_cfg_bad;
      r_hm_clear <= w_clear;
      r_pend     <= (r_state == S_IDLE) && cfg_clear && (cfg_start || r_pend);
      r_irq      <= (w_accept && w_cfg_bad) || w_finish;
      if (w_accept) r_err <= w_cfg_bad;
      if (w_latch) begin
        r_base  <= w_sel_base;
        r_bands <= w_sel_bands;
        r_lib   <= w_sel_lib;
      end
      if (w_finish) begin
        r_min_ref <= hm_mse_min_ref;
        r_max_ref <= hm_mse_max_ref;
        r_min_val <= hm_mse_min_value;
        r_max_val <= hm_mse_max_value;
      end
    end
  end

  // Word counters, read credits and the read-data FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nwords  <= '0;
      r_req_cnt <= '0;
      r_pop_cnt <= '0;
      r_infl    <= '0;
      r_fcnt    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_accept) begin
        r_nwords  <= w_nwords;
        r_req_cnt <= '0;
        r_pop_cnt <= '0;
      end else begin
        if (w_fire) r_req_cnt <= r_req_cnt + CW'(1);
        if (w_pop)  r_pop_cnt <= r_pop_cnt + CW'(1);
      end
      r_infl <= r_infl + FW'(w_fire) - FW'(w_push);
      r_fcnt <= r_fcnt + FW'(w_push) - FW'(w_pop);
      if (w_push) begin
        r_mem[r_wr_ptr] <= mem_rdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign irq           = r_irq;
  assign err           = r_err;
  assign res_min_ref   = r_min_ref;
  assign res_max_ref   = r_max_ref;
  assign res_min_value = r_min_val;
  assign res_max_value = r_max_val;
  assign mem_req       = w_mem_req;
  assign mem_addr      = {w_addr_sum[ADDR_WIDTH-1:2], 2'b00};
  assign hm_start      = r_hm_start;
  assign hm_clear      = r_hm_clear;
  assign hm_bands      = r_bands;
  assign hm_lib_size   = r_lib;
  assign hm_vctr_valid = w_pop;
  assign hm_vctr       = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_hsid_stream_ctrl.sv
// Directed bench for hsid_stream_ctrl: a memory responder and a stand-in hsid_main run
// beside a linear sequence of jobs, error configs, clear pulses and a mid-stream reset.
module tb_hsid_stream_ctrl;

  localparam int unsigned LW = 8;
  localparam int unsigned BW = 7;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start, cfg_clear;
  logic [31:0]   cfg_base_addr;
  logic [BW-1:0] cfg_bands;
  logic [LW-1:0] cfg_lib_size;
  logic          busy, irq, err;
  logic [LW-1:0] res_min_ref, res_max_ref;
  logic [31:0]   res_min_value, res_max_value;
  logic          mem_req, mem_gnt, mem_rvalid;
  logic [31:0]   mem_addr, mem_rdata;
  logic          hm_start, hm_clear, hm_vctr_valid, hm_ready, hm_done;
  logic [BW-1:0] hm_bands;
  logic [LW-1:0] hm_lib_size;
  logic [31:0]   hm_vctr;
  logic [LW-1:0] hm_mse_min_ref, hm_mse_max_ref;
  logic [31:0]   hm_mse_min_value, hm_mse_max_value;

  hsid_stream_ctrl dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_clear(cfg_clear),
    .cfg_base_addr(cfg_base_addr), .cfg_bands(cfg_bands), .cfg_lib_size(cfg_lib_size),
    .busy(busy), .irq(irq), .err(err),
    .res_min_ref(res_min_ref), .res_max_ref(res_max_ref),
    .res_min_value(res_min_value), .res_max_value(res_max_value),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .hm_start(hm_start), .hm_clear(hm_clear), .hm_bands(hm_bands), .hm_lib_size(hm_lib_size),
    .hm_vctr_valid(hm_vctr_valid), .hm_vctr(hm_vctr), .hm_ready(hm_ready), .hm_done(hm_done),
    .hm_mse_min_ref(hm_mse_min_ref), .hm_mse_max_ref(hm_mse_max_ref),
    .hm_mse_min_value(hm_mse_min_value), .hm_mse_max_value(hm_mse_max_value)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_img [64];
  logic [31:0] q_addr [$];
  int          q_due [$];
  int cyc = 0, last_due = 0;
  int pop_idx = 0, req_seen = 0, exp_n = 0, max_out = 0;
  int start_cnt = 0, clear_cnt = 0, irq_cnt = 0, req_any = 0, done_wait = 0;
  int first_pop = 0, last_pop = 0, clear_cyc = 0, start_cyc = 0;
  int max_lat = 1, gap_at = 0, gap_left = 0;
  bit job_active = 0, done_sent = 0, gnt_rand = 0;
  bit poke_en = 0, poke_done = 0, poke_release = 0;
  logic [LW-1:0] exp_min_ref, exp_max_ref;
  logic [31:0]   exp_min_val, exp_max_val;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder and hsid_main stand-in; inputs change on the falling edge
  initial begin : env
    int lat, due;
    logic [31:0] off;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; hm_ready = 1; hm_done = 0;
    hm_mse_min_ref = '0; hm_mse_max_ref = '0; hm_mse_min_value = '0; hm_mse_max_value = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q_addr.delete(); q_due.delete(); last_due = 0;
        mem_rvalid = 0; mem_gnt = 0; hm_done = 0;
        continue;
      end
      mem_rvalid = 0;
      mem_rdata  = $urandom;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        off        = (q_addr[0] - BASE) >> 2;
        mem_rvalid = 1;
        mem_rdata  = mem_img[off[5:0]];
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (gap_left > 0 && pop_idx >= gap_at) begin
        hm_ready = 0;
        gap_left--;
      end else begin
        hm_ready = 1;
      end
      hm_done = 0;
      hm_mse_min_ref = LW'($urandom); hm_mse_max_ref = LW'($urandom);
      hm_mse_min_value = $urandom;    hm_mse_max_value = $urandom;
      if (job_active && !done_sent && pop_idx == exp_n) begin
        done_wait++;
        if (done_wait >= 3) begin
          hm_done = 1; done_sent = 1;
          hm_mse_min_ref = exp_min_ref;   hm_mse_max_ref = exp_max_ref;
          hm_mse_min_value = exp_min_val; hm_mse_max_value = exp_max_val;
        end
      end
      if (poke_release) begin
        cfg_start = 0; cfg_clear = 0; poke_release = 0;
      end
      if (poke_en && !poke_done && pop_idx >= 3) begin
        cfg_start = 1; cfg_clear = 1; cfg_bands = 7'd2; cfg_lib_size = 8'd1;
        poke_done = 1; poke_release = 1;
      end
      #1;
      if (hm_start) begin start_cnt++; start_cyc = cyc; end
      if (hm_clear) begin clear_cnt++; clear_cyc = cyc; end
      if (mem_req) req_any++;
      if (irq) begin
        irq_cnt++;
        check("busy_low_with_irq", busy, 0);
      end
      if (mem_req && mem_gnt) begin
        check("mem_addr", mem_addr, BASE + 32'(4 * req_seen));
        lat = (max_lat > 1) ? int'($urandom_range(1, max_lat)) : 1;
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        q_addr.push_back(mem_addr);
        q_due.push_back(due);
        req_seen++;
      end
      if (!hm_ready) check("valid_while_not_ready", hm_vctr_valid, 0);
      if (hm_vctr_valid) begin
        check("stream_word", hm_vctr, (pop_idx < 64) ? mem_img[pop_idx] : 32'hDEAD_BEEF);
        if (pop_idx == 0) first_pop = cyc;
        last_pop = cyc;
        pop_idx++;
      end
      if (req_seen - pop_idx > max_out) max_out = req_seen - pop_idx;
    end
  end

  task automatic arm_job(input int bands, input int lib, input bit gr, input int ml,
                         input int gat, input int glen, input bit poke);
    for (int i = 0; i < 64; i++) mem_img[i] = $urandom;
    exp_min_ref = LW'($urandom); exp_max_ref = LW'($urandom);
    exp_min_val = $urandom;      exp_max_val = $urandom;
    pop_idx = 0; req_seen = 0; exp_n = (bands / 2) * (lib + 1); max_out = 0;
    start_cnt = 0; clear_cnt = 0; irq_cnt = 0; done_wait = 0; done_sent = 0;
    gnt_rand = gr; max_lat = ml; gap_at = gat; gap_left = glen;
    poke_en = poke; poke_done = 0; job_active = 1;
  endtask

  task automatic run_job(input string tag, input int bands, input int lib, input bit gr,
                         input int ml, input int gat, input int glen, input bit poke,
                         input bit clr, input bit tput);
    @(negedge clk);
    arm_job(bands, lib, gr, ml, gat, glen, poke);
    cfg_start = 1; cfg_clear = clr; cfg_base_addr = BASE;
    cfg_bands = BW'(bands); cfg_lib_size = LW'(lib);
    @(negedge clk);
    cfg_start = 0; cfg_clear = 0; cfg_bands = '0; cfg_lib_size = '0; cfg_base_addr = '0;
    for (int i = 0; i < 3000 && irq_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2;
    check({tag, "_irq_count"}, irq_cnt, 1);
    check({tag, "_start_count"}, start_cnt, 1);
    check({tag, "_words_popped"}, pop_idx, exp_n);
    check({tag, "_words_requested"}, req_seen, exp_n);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_min_ref"}, res_min_ref, exp_min_ref);
    check({tag, "_max_ref"}, res_max_ref, exp_max_ref);
    check({tag, "_min_value"}, res_min_value, exp_min_val);
    check({tag, "_max_value"}, res_max_value, exp_max_val);
    check({tag, "_hm_bands"}, hm_bands, bands);
    check({tag, "_hm_lib_size"}, hm_lib_size, lib);
    check({tag, "_clear_count"}, clear_cnt, clr);
    check({tag, "_outstanding_le_4"}, max_out <= 4, 1);
    if (tput) check({tag, "_one_word_per_cycle"}, last_pop - first_pop, exp_n - 1);
    if (clr)  check({tag, "_clear_before_start"}, start_cyc > clear_cyc, 1);
    job_active = 0; poke_en = 0; gnt_rand = 0; max_lat = 1;
  endtask

  task automatic run_err(input string tag, input int bands, input int lib);
    @(negedge clk);
    start_cnt = 0; irq_cnt = 0; req_any = 0; job_active = 0;
    cfg_start = 1; cfg_base_addr = BASE; cfg_bands = BW'(bands); cfg_lib_size = LW'(lib);
    @(negedge clk);
    cfg_start = 0;
    repeat (5) @(negedge clk);
    #2;
    check({tag, "_err"}, err, 1);
    check({tag, "_irq_count"}, irq_cnt, 1);
    check({tag, "_no_mem_req"}, req_any, 0);
    check({tag, "_no_hm_start"}, start_cnt, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin : stim
    rst = 1; cfg_start = 0; cfg_clear = 0; cfg_base_addr = '0; cfg_bands = '0; cfg_lib_size = '0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    check("rst_err", err, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_hm_start", hm_start, 0);
    check("rst_hm_clear", hm_clear, 0);
    check("rst_hm_vctr_valid", hm_vctr_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 0;

    run_job("basic", 4, 3, 0, 1, 0, 0, 0, 0, 1);
    run_job("random_gnt", 4, 3, 1, 4, 0, 0, 0, 0, 0);
    run_job("random_gnt_big", 8, 7, 1, 4, 0, 0, 0, 0, 0);
    run_job("ready_gap", 6, 4, 0, 1, 3, 5, 0, 0, 0);

    run_err("odd_bands", 3, 2);
    run_err("zero_lib", 4, 0);
    run_err("zero_bands", 0, 2);

    // Lone clear in IDLE
    @(negedge clk);
    clear_cnt = 0; start_cnt = 0;
    cfg_clear = 1;
    @(negedge clk);
    cfg_clear = 0;
    repeat (3) @(negedge clk);
    #2;
    check("idle_clear_count", clear_cnt, 1);
    check("idle_clear_no_start", start_cnt, 0);
    check("idle_clear_busy", busy, 0);

    run_job("start_with_clear", 4, 2, 0, 1, 0, 0, 0, 1, 0);
    run_job("start_while_busy", 4, 5, 0, 2, 0, 0, 1, 0, 0);

    // Abort in the middle of a stream
    @(negedge clk);
    arm_job(4, 3, 0, 2, 0, 0, 0);
    cfg_start = 1; cfg_base_addr = BASE; cfg_bands = 7'd4; cfg_lib_size = 8'd3;
    @(negedge clk);
    cfg_start = 0;
    for (int i = 0; i < 200 && pop_idx < 5; i++) begin
      @(negedge clk);
      #2;
    end
    check("abort_reached_5_words", pop_idx, 5);
    rst = 1; irq_cnt = 0; job_active = 0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_mem_req", mem_req, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_hm_vctr_valid", hm_vctr_valid, 0);
    check("abort_hm_vctr", hm_vctr, 0);
    check("abort_hm_bands", hm_bands, 0);
    check("abort_hm_lib_size", hm_lib_size, 0);
    check("abort_res_max_value", res_max_value, 0);
    check("abort_res_min_ref", res_min_ref, 0);
    check("abort_irq", irq, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    #2;
    check("abort_no_irq", irq_cnt, 0);
    run_job("after_abort", 4, 3, 0, 1, 0, 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
